// File: rtl/ga_pkg.sv
// Shared constants and mode encoding for the gate-array raster interrupt block.
package ga_pkg;

   localparam int unsigned GA_LINE_DIV = 52;
   localparam int unsigned GA_CNT_W    = 6;
   localparam int unsigned GA_VS_DELAY = 2;
   localparam int unsigned GA_LINE_W   = 9;

   typedef enum logic {
      ModeDivider = 1'b0,
      ModeRaster  = 1'b1
   } ga_mode_e;

endpackage

// File: rtl/ga_edge_det.sv
// Registered rise/fall detector; history and outputs advance only on cen.
module ga_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cen_i,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else if (cen_i) begin
         prev_q <= sig_i;
         rise_q <= sig_i & ~prev_q;
         fall_q <= ~sig_i & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ga_raster_irq.sv
// Raster interrupt generator: HSYNC divider with VSYNC resync, or compare on a
// programmable line count.
module ga_raster_irq
   import ga_pkg::*;
#(
   parameter int unsigned LINE_DIV = GA_LINE_DIV,
   parameter int unsigned CNT_W    = GA_CNT_W,
   parameter int unsigned VS_DELAY = GA_VS_DELAY,
   parameter int unsigned LINE_W   = GA_LINE_W
) (
   input  logic              clk,
   input  logic              RESET_N,
   input  logic              cen,
   input  logic              HSYNC_I,
   input  logic              VSYNC_I,
   input  logic              int_ack,
   input  logic              irq_reset,
   input  logic              mode_pri,
   input  logic [LINE_W-1:0] pri_line,
   output logic              INT_N,
   output logic [CNT_W-1:0]  HCNT,
   output logic [LINE_W-1:0] LINE,
   output logic              VS_PEND
);

   localparam int unsigned DLY_W = (VS_DELAY > 1) ? $clog2(VS_DELAY + 1) : 1;

   logic [1:0]        rst_sync_q;
   logic              rst_n_int;
   logic              hs_end, vs_rise, hs_rise, vs_fall;
   logic              unused_edges;

   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [DLY_W-1:0]  delay_q, delay_d;
   logic              vs_pend_q, vs_pend_d;
   logic              pend_q, pend_d;
   logic              int_n_q;
   logic              div_set, pri_hit, set_pend, raster;

   // Assert asynchronously, release two clocks later.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_int = rst_sync_q[1];

   ga_edge_det u_hs_det (
      .clk_i  (clk),
      .rst_ni (rst_n_int),
      .cen_i  (cen),
      .sig_i  (HSYNC_I),
      .rise_o (hs_rise),
      .fall_o (hs_end)
   );

   ga_edge_det u_vs_det (
      .clk_i  (clk),
      .rst_ni (rst_n_int),
      .cen_i  (cen),
      .sig_i  (VSYNC_I),
      .rise_o (vs_rise),
      .fall_o (vs_fall)
   );

   assign unused_edges = hs_rise ^ vs_fall;
   assign raster       = (ga_mode_e'(mode_pri) == ModeRaster);

   always_comb begin
      hcnt_d    = hcnt_q;
      line_d    = line_q;
      delay_d   = delay_q;
      vs_pend_d = vs_pend_q;
      pend_d    = pend_q;
      div_set   = 1'b0;

      if (hs_end && (line_q != '1)) line_d = line_q + 1'b1;
      if (vs_rise) begin
         line_d    = '0;
         delay_d   = DLY_W'(VS_DELAY);
         vs_pend_d = 1'b1;
      end

      if (hs_end) begin
         if (vs_pend_q && !vs_rise && (delay_q == DLY_W'(1))) begin
            // Resync replaces the divider step; interrupt only if past half count.
            hcnt_d    = '0;
            vs_pend_d = 1'b0;
            delay_d   = '0;
            div_set   = hcnt_q[CNT_W-1];
         end else begin
            if (vs_pend_q && !vs_rise) delay_d = delay_q - 1'b1;
            if (hcnt_q == CNT_W'(LINE_DIV - 1)) begin
               hcnt_d  = '0;
               div_set = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
      end

      pri_hit  = (line_d != line_q) && (line_d == pri_line) && (pri_line != '0);
      set_pend = raster ? pri_hit : div_set;

      if (int_ack) begin
         pend_d = 1'b0;
         if (!raster) hcnt_d[CNT_W-1] = 1'b0;
      end
      if (set_pend) pend_d = 1'b1;
      if (irq_reset) begin
         pend_d    = 1'b0;
         hcnt_d    = '0;
         vs_pend_d = 1'b0;
         delay_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         hcnt_q    <= '0;
         line_q    <= '0;
         delay_q   <= '0;
         vs_pend_q <= 1'b0;
         pend_q    <= 1'b0;
         int_n_q   <= 1'b1;
      end else if (cen) begin
         hcnt_q    <= hcnt_d;
         line_q    <= line_d;
         delay_q   <= delay_d;
         vs_pend_q <= vs_pend_d;
         pend_q    <= pend_d;
         int_n_q   <= ~pend_d;
      end
   end

   assign INT_N   = int_n_q;
   assign HCNT    = hcnt_q;
   assign LINE    = line_q;
   assign VS_PEND = vs_pend_q;

endmodule

// File: tb/tb_ga_raster_irq.sv
// Directed bench for ga_raster_irq with hand-computed expectations.
module tb_ga_raster_irq;

   logic       clk = 1'b0;
   logic       RESET_N;
   logic       cen, HSYNC_I, VSYNC_I, int_ack, irq_reset, mode_pri;
   logic [8:0] pri_line;
   logic       INT_N;
   logic [5:0] HCNT;
   logic [8:0] LINE;
   logic       VS_PEND;

   int checks = 0;
   int errors = 0;

   ga_raster_irq dut (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .cen       (cen),
      .HSYNC_I   (HSYNC_I),
      .VSYNC_I   (VSYNC_I),
      .int_ack   (int_ack),
      .irq_reset (irq_reset),
      .mode_pri  (mode_pri),
      .pri_line  (pri_line),
      .INT_N     (INT_N),
      .HCNT      (HCNT),
      .LINE      (LINE),
      .VS_PEND   (VS_PEND)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One HSYNC end; ack/ir are applied in the cycle the end is acted on.
   task automatic hs_end_x(input logic ack, input logic ir);
      HSYNC_I = 1'b1;
      tick();
      HSYNC_I = 1'b0;
      tick();
      int_ack   = ack;
      irq_reset = ir;
      tick();
      int_ack   = 1'b0;
      irq_reset = 1'b0;
   endtask

   task automatic hs_ends(input int n);
      for (int i = 0; i < n; i++) hs_end_x(1'b0, 1'b0);
   endtask

   task automatic vs_rise();
      VSYNC_I = 1'b1;
      tick();
      tick();
      VSYNC_I = 1'b0;
      tick();
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic pulse_irq_reset();
      irq_reset = 1'b1;
      tick();
      irq_reset = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b1; cen = 1'b1; HSYNC_I = 1'b0; VSYNC_I = 1'b0;
      int_ack = 1'b0; irq_reset = 1'b0; mode_pri = 1'b0; pri_line = 9'd0;
      #2 RESET_N = 1'b0;
      tick();
      tick();
      chk("rst_int_n", INT_N, 1);
      chk("rst_hcnt", HCNT, 0);
      chk("rst_line", LINE, 0);
      chk("rst_vs_pend", VS_PEND, 0);
      RESET_N = 1'b1;
      tick(); tick(); tick();

      // Divider: interrupt every 52 HSYNC ends
      hs_ends(51);
      chk("div51_int_n", INT_N, 1);
      chk("div51_hcnt", HCNT, 51);
      hs_ends(1);
      chk("div52_int_n", INT_N, 0);
      chk("div52_hcnt", HCNT, 0);
      chk("div52_line", LINE, 52);
      pulse_ack();
      chk("div_ack_int_n", INT_N, 1);
      hs_ends(51);
      chk("div103_int_n", INT_N, 1);
      hs_ends(1);
      chk("div104_int_n", INT_N, 0);
      chk("div104_hcnt", HCNT, 0);
      chk("div104_line", LINE, 104);
      pulse_ack();

      // Ack clears HCNT MSB in divider mode: 45 -> 13
      hs_ends(45);
      chk("ack45_hcnt_pre", HCNT, 45);
      pulse_ack();
      chk("ack45_hcnt", HCNT, 13);
      chk("ack45_int_n", INT_N, 1);

      // Resync at HCNT=40 -> interrupt
      hs_ends(27);
      chk("rs40_hcnt_pre", HCNT, 40);
      vs_rise();
      chk("rs40_vs_pend", VS_PEND, 1);
      chk("rs40_line0", LINE, 0);
      hs_ends(1);
      chk("rs40_hcnt_mid", HCNT, 41);
      chk("rs40_vs_pend_mid", VS_PEND, 1);
      hs_ends(1);
      chk("rs40_hcnt", HCNT, 0);
      chk("rs40_vs_pend_done", VS_PEND, 0);
      chk("rs40_int_n", INT_N, 0);
      pulse_ack();
      chk("rs40_ack_int_n", INT_N, 1);

      // Resync at HCNT=20 -> no interrupt
      hs_ends(20);
      vs_rise();
      hs_ends(2);
      chk("rs20_hcnt", HCNT, 0);
      chk("rs20_int_n", INT_N, 1);
      chk("rs20_line", LINE, 2);

      // VSYNC rise during resync reloads the delay
      vs_rise();
      hs_ends(1);
      vs_rise();
      hs_ends(1);
      chk("reload_vs_pend", VS_PEND, 1);
      chk("reload_hcnt_mid", HCNT, 2);
      hs_ends(1);
      chk("reload_vs_done", VS_PEND, 0);
      chk("reload_hcnt", HCNT, 0);
      chk("reload_int_n", INT_N, 1);

      // Collision: set beats ack
      hs_ends(51);
      hs_end_x(1'b1, 1'b0);
      chk("col_ack_int_n", INT_N, 0);
      chk("col_ack_hcnt", HCNT, 0);
      pulse_ack();

      // cen=0 freezes everything
      hs_ends(51);
      cen = 1'b0;
      hs_ends(1);
      cen = 1'b1;
      tick();
      chk("cen_hold_hcnt", HCNT, 51);

      // Collision: irq_reset beats set
      hs_end_x(1'b0, 1'b1);
      chk("col_rst_int_n", INT_N, 1);
      chk("col_rst_hcnt", HCNT, 0);

      // irq_reset clears a pending resync
      vs_rise();
      chk("irst_vs_pend_pre", VS_PEND, 1);
      pulse_irq_reset();
      chk("irst_vs_pend", VS_PEND, 0);

      // Programmable raster at line 100
      mode_pri = 1'b1;
      pri_line = 9'd100;
      vs_rise();
      hs_ends(99);
      chk("pri99_int_n", INT_N, 1);
      chk("pri99_line", LINE, 99);
      hs_ends(1);
      chk("pri100_int_n", INT_N, 0);
      chk("pri100_hcnt", HCNT, 46);
      pulse_ack();
      chk("pri_ack_int_n", INT_N, 1);
      chk("pri_ack_hcnt", HCNT, 46);
      hs_ends(10);
      chk("pri110_int_n", INT_N, 1);
      chk("pri110_hcnt", HCNT, 4);

      // Compare disabled over a full frame; LINE saturates
      pri_line = 9'd0;
      vs_rise();
      hs_ends(520);
      chk("pri0_int_n", INT_N, 1);
      chk("pri0_line_sat", LINE, 511);
      chk("pri0_hcnt", HCNT, 50);

      // Reset mid-resync abandons everything
      mode_pri = 1'b0;
      pulse_irq_reset();
      hs_ends(33);
      chk("mid_hcnt_pre", HCNT, 33);
      vs_rise();
      chk("mid_vs_pend_pre", VS_PEND, 1);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_int_n", INT_N, 1);
      chk("mid_rst_hcnt", HCNT, 0);
      chk("mid_rst_line", LINE, 0);
      chk("mid_rst_vs_pend", VS_PEND, 0);
      tick();
      RESET_N = 1'b1;
      tick(); tick(); tick();
      hs_ends(51);
      chk("post_rst51_int_n", INT_N, 1);
      chk("post_rst51_vs_pend", VS_PEND, 0);
      hs_ends(1);
      chk("post_rst52_int_n", INT_N, 0);
      chk("post_rst52_hcnt", HCNT, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
